// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared event codes and per-key hold FSM states for key_event_ctrl.
package key_pkg;

  localparam logic [1:0] EVT_PRESS   = 2'd0;
  localparam logic [1:0] EVT_LONG    = 2'd1;
  localparam logic [1:0] EVT_REPEAT  = 2'd2;
  localparam logic [1:0] EVT_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } key_state_e;

endpackage

// File: rtl/key_hold_fsm.sv
// rtl/key_hold_fsm.sv - one key's hold FSM, hold counter and single-entry pending event slot.
module key_hold_fsm
  import key_pkg::*;
#(
  parameter int LONG_TICKS   = 100,
  parameter int REPEAT_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       smp,
  input  logic       grant,
  output logic       pv,
  output logic [1:0] ptype,
  output logic       lost
);

  localparam int MAX_TICKS = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int HW        = $clog2(MAX_TICKS + 1);

  key_state_e    state, state_nxt;
  logic [HW-1:0] hcnt, hcnt_nxt, hcnt_inc;
  logic          evt;
  logic [1:0]    evt_type;

  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt;
    hcnt_inc  = hcnt + 1'b1;
    evt       = 1'b0;
    evt_type  = EVT_PRESS;
    if (step) begin
      case (state)
        ST_IDLE: begin
          if (smp) begin
            evt       = 1'b1;
            evt_type  = EVT_PRESS;
            state_nxt = ST_PRESSED;
            hcnt_nxt  = '0;
          end
        end
        ST_PRESSED: begin
          if (!smp) begin
            evt       = 1'b1;
            evt_type  = EVT_RELEASE;
            state_nxt = ST_IDLE;
          end else if (hcnt_inc == HW'(LONG_TICKS)) begin
            evt       = 1'b1;
            evt_type  = EVT_LONG;
            state_nxt = ST_HELD;
            hcnt_nxt  = '0;
          end else begin
            hcnt_nxt = hcnt_inc;
          end
        end
        ST_HELD: begin
          if (!smp) begin
            evt       = 1'b1;
            evt_type  = EVT_RELEASE;
            state_nxt = ST_IDLE;
          end else if (hcnt_inc == HW'(REPEAT_TICKS)) begin
            evt      = 1'b1;
            evt_type = EVT_REPEAT;
            hcnt_nxt = '0;
          end else begin
            hcnt_nxt = hcnt_inc;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // A grant in the same cycle hands the old event out, so only an ungranted full slot loses one.
  assign lost = evt && pv && !grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      hcnt  <= '0;
      pv    <= 1'b0;
      ptype <= EVT_PRESS;
    end else begin
      state <= state_nxt;
      hcnt  <= hcnt_nxt;
      if (evt) begin
        pv    <= 1'b1;
        ptype <= evt_type;
      end else if (grant) begin
        pv <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/key_event_ctrl.sv
// rtl/key_event_ctrl.sv - tick sampling of W keys, per-key hold FSMs and round-robin event output.
module key_event_ctrl
  import key_pkg::*;
#(
  parameter int W            = 4,
  parameter int TICK_DIV     = 1000000,
  parameter int LONG_TICKS   = 100,
  parameter int REPEAT_TICKS = 20
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [W-1:0]                        keylvl,
  output logic                                evt_valid,
  input  logic                                evt_ready,
  output logic [((W > 1) ? $clog2(W) : 1)-1:0] evt_key,
  output logic [1:0]                          evt_type,
  output logic                                ovf,
  input  logic                                ovf_clr
);

  localparam int KW = (W > 1) ? $clog2(W) : 1;
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          tick, tick_d;
  logic [W-1:0]  key_smp;
  logic [W-1:0]  pv, grant, lost;
  logic [1:0]    ptype [W];
  logic [KW-1:0] ptr, gidx;
  logic [1:0]    gtype;
  logic          found, load;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      tick_d  <= 1'b0;
      key_smp <= '0;
    end else begin
      cnt    <= tick ? '0 : cnt + 1'b1;
      tick_d <= tick;
      if (tick) key_smp <= keylvl;
    end
  end

  for (genvar g = 0; g < W; g++) begin : g_key
    key_hold_fsm #(
      .LONG_TICKS  (LONG_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS)
    ) u_fsm (
      .clk  (clk),
      .rst  (rst),
      .step (tick_d),
      .smp  (key_smp[g]),
      .grant(grant[g]),
      .pv   (pv[g]),
      .ptype(ptype[g]),
      .lost (lost[g])
    );
  end

  // Two passes give the cyclic search: keys above the pointer first, then wrap to the rest.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    gtype = EVT_PRESS;
    for (int k = 0; k < W; k++) begin
      if (!found && pv[k] && (k > int'(ptr))) begin
        found = 1'b1;
        gidx  = KW'(k);
        gtype = ptype[k];
      end
    end
    for (int k = 0; k < W; k++) begin
      if (!found && pv[k] && (k <= int'(ptr))) begin
        found = 1'b1;
        gidx  = KW'(k);
        gtype = ptype[k];
      end
    end
  end

  assign load  = !evt_valid || evt_ready;
  assign grant = (load && found) ? (W'(1) << gidx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_key   <= '0;
      evt_type  <= EVT_PRESS;
      ptr       <= KW'(W - 1);
      ovf       <= 1'b0;
    end else begin
      if (load) begin
        evt_valid <= found;
        if (found) begin
          evt_key  <= gidx;
          evt_type <= gtype;
          ptr      <= gidx;
        end
      end
      if (|lost)        ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule

// File: doc/key_event_ctrl.md
Name: key_event_ctrl

Overview:
- Sequences front-panel key handling for W keys.
- Samples debounced key levels on a shared 10 ms tick and runs a per-key hold FSM.
- Each FSM produces PRESS / LONG / REPEAT / RELEASE events.
- A round-robin arbiter serialises those events onto a single valid/ready event stream for the menu/control logic.

Parameters:
- W, 4, number of keys (1..16).
- TICK_DIV, 1000000, clk cycles per sample tick (10 ms at 100 MHz).
- LONG_TICKS, 100, ticks from PRESS to LONG (1 s).
- REPEAT_TICKS, 20, ticks between successive REPEATs (200 ms).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- keylvl  in  W  debounced key levels, 1 = pressed.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts the event when valid && ready.
- evt_key  out  $clog2(W) (min 1)  index of the key.
- evt_type  out  2  0 = PRESS, 1 = LONG, 2 = REPEAT, 3 = RELEASE.
- ovf  out  1  sticky: an event was lost.
- ovf_clr  in  1  clears ovf.

Behaviour:
- Reset: tick counter, key_smp, all FSMs (IDLE), hold counters, pending slots, evt_valid, evt_key, evt_type and ovf all go to 0. The round-robin pointer resets to W-1, so key 0 has first priority.
- Tick counter: runs 0..TICK_DIV-1 and wraps. tick = (cnt == TICK_DIV-1).
- Cycle T (tick high): key_smp <= keylvl at the T+1 edge.
- Cycle T+1: every FSM steps once on key_smp. Any event is written to that key's pending slot at the T+2 edge.
- Per-key FSM:
  - IDLE, smp=1: emit PRESS, go to PRESSED, hcnt=0.
  - PRESSED, smp=0: emit RELEASE, go to IDLE.
  - PRESSED, smp=1: hcnt++. When hcnt reaches LONG_TICKS, emit LONG, go to HELD, hcnt=0.
  - HELD, smp=1: hcnt++. When hcnt reaches REPEAT_TICKS, emit REPEAT, hcnt=0.
  - HELD, smp=0: emit RELEASE, go to IDLE.
  - hcnt width is $clog2(max(LONG_TICKS, REPEAT_TICKS)+1). No saturation is needed because it always resets at the threshold.
- Pending slot (one per key: pv, ptype):
  - A new event when pv=0 writes the slot.
  - A new event when pv=1 and the slot is not granted this cycle overwrites ptype and sets ovf.
  - A new event in the same cycle as that slot's grant: the grant takes the old value, the new value is written, and there is no ovf.
- Output register:
  - Loads when evt_valid=0, or when evt_valid && evt_ready.
  - The grant goes to the first pv=1 key after the rr pointer, searching cyclically. The grant clears that pv, sets the pointer to the granted key, and drives evt_valid=1 with key and type.
  - If nothing is pending on a handshake cycle, evt_valid goes to 0.
  - While evt_valid && !evt_ready, evt_key and evt_type hold stable.
- Throughput: one event per cycle when ready is held high.
- Latency: with the output idle, a PRESS sampled on the tick in cycle T has evt_valid=1 in cycle T+3.
- ovf: ovf_clr clears ovf unless a new loss occurs in the same cycle; a loss wins.
- Reset mid-hold: the FSM returns to IDLE and key_smp=0. A key still held produces a fresh PRESS on the first tick after reset, with no RELEASE.

Decomposition:
- Package key_pkg holds:
  - evt_type localparams EVT_PRESS/LONG/REPEAT/RELEASE.
  - FSM state encodings ST_IDLE/PRESSED/HELD.
- Sub-module key_hold_fsm: one key's FSM, hcnt and pending slot. Instantiated W times via generate.
- The top holds the tick counter, key_smp, the round-robin arbiter, the output register and ovf.

Test Plan (W=4, TICK_DIV=4, LONG_TICKS=3, REPEAT_TICKS=2, evt_ready=1 unless stated):
- Short press: key1 high for ticks t0..t1, low at t2 -> (key1, PRESS) at the t0 tick cycle + 3, (key1, RELEASE) 3 cycles after t2. No LONG, ovf=0.
- Long hold: key0 high over ticks t0..t7, low at t8 -> PRESS@t0, LONG@t3, REPEAT@t5, REPEAT@t7, RELEASE@t8, each visible at tick cycle + 3.
- Simultaneous press: keys 0, 2, 3 rise before the same tick -> PRESS for key0, key2, key3 on 3 consecutive cycles. A simultaneous release later yields key0, key2, key3 again, with the pointer wrapping from 3.
- Backpressure: evt_ready=0 while key1 presses (t0) and releases (t2) -> PRESS held stable on the outputs. After ready rises, PRESS then RELEASE are delivered on consecutive cycles, ovf=0. Repeating with press/release/press while stalled -> ovf=1; ovf_clr pulse -> ovf=0.
- Reset mid-operation: key0 in HELD, rst for 2 cycles with key0 still high -> evt_valid=0 and ovf=0 during reset. PRESS (key0) appears after the first post-reset tick, LONG 3 ticks later.
